// File: rtl/age_ordered_rs.sv
// Age-matrix reservation station: holds renamed uops until operands arrive, issues oldest-first.
// Optional: define RS_CDB_BYPASS_EN so a CDB-woken entry can issue in the same cycle as the broadcast.
module age_ordered_rs #(
  parameter int RS_ENTRIES = 16,
  parameter int ALLOC_W    = 2,
  parameter int ISSUE_W    = 2,
  parameter int CDB_W      = 2,
  parameter int PHYS_W     = 6,
  parameter int DATA_W     = 64,
  parameter int OP_W       = 8,
  parameter int ROB_W      = 6,
  localparam int CNT_W     = $clog2(RS_ENTRIES + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ALLOC_W-1:0]               alloc_en,
  input  logic [ALLOC_W-1:0][OP_W-1:0]     alloc_op,
  input  logic [ALLOC_W-1:0][PHYS_W-1:0]   alloc_dst_tag,
  input  logic [ALLOC_W-1:0][ROB_W-1:0]    alloc_rob_tag,
  input  logic [ALLOC_W-1:0][PHYS_W-1:0]   alloc_src1_tag,
  input  logic [ALLOC_W-1:0][PHYS_W-1:0]   alloc_src2_tag,
  input  logic [ALLOC_W-1:0][DATA_W-1:0]   alloc_src1_val,
  input  logic [ALLOC_W-1:0][DATA_W-1:0]   alloc_src2_val,
  input  logic [ALLOC_W-1:0]               alloc_src1_ready,
  input  logic [ALLOC_W-1:0]               alloc_src2_ready,
  output logic                             alloc_ready,
  output logic [CNT_W-1:0]                 free_count,
  input  logic [CDB_W-1:0]                 cdb_valid,
  input  logic [CDB_W-1:0][PHYS_W-1:0]     cdb_tag,
  input  logic [CDB_W-1:0][DATA_W-1:0]     cdb_value,
  output logic [ISSUE_W-1:0]               issue_valid,
  input  logic [ISSUE_W-1:0]               issue_ready,
  output logic [ISSUE_W-1:0][OP_W-1:0]     issue_op,
  output logic [ISSUE_W-1:0][PHYS_W-1:0]   issue_dst_tag,
  output logic [ISSUE_W-1:0][ROB_W-1:0]    issue_rob_tag,
  output logic [ISSUE_W-1:0][DATA_W-1:0]   issue_src1_val,
  output logic [ISSUE_W-1:0][DATA_W-1:0]   issue_src2_val,
  input  logic                             flush_all,
  input  logic                             flush_en,
  input  logic [ROB_W-1:0]                 flush_rob_tag,
  input  logic [ROB_W-1:0]                 rob_head_tag
);
  localparam int IDX_W = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

  // Control state (reset)
  logic [RS_ENTRIES-1:0]                 ent_vld, s1_rdy, s2_rdy;
  // older[i][j] set means entry i was allocated before entry j
  logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] older;
  // Payload state (no reset)
  logic [RS_ENTRIES-1:0][OP_W-1:0]       ent_op;
  logic [RS_ENTRIES-1:0][PHYS_W-1:0]     ent_dst, s1_tag, s2_tag;
  logic [RS_ENTRIES-1:0][ROB_W-1:0]      ent_rob;
  logic [RS_ENTRIES-1:0][DATA_W-1:0]     s1_val, s2_val;

  function automatic logic is_younger(input logic [ROB_W-1:0] tag,
                                      input logic [ROB_W-1:0] brn_tag,
                                      input logic [ROB_W-1:0] head);
    logic [ROB_W-1:0] tag_age, brn_age;
    tag_age = tag - head;
    brn_age = brn_tag - head;
    return tag_age > brn_age;
  endfunction

  // Lowest CDB port wins: scan downward so the last hit written is the lowest index.
  function automatic logic [DATA_W:0] cdb_lookup(input logic [PHYS_W-1:0] tag,
                                                 input logic [CDB_W-1:0] vld,
                                                 input logic [CDB_W-1:0][PHYS_W-1:0] tags,
                                                 input logic [CDB_W-1:0][DATA_W-1:0] vals);
    logic [DATA_W:0] res;
    res = '0;
    for (int c = CDB_W - 1; c >= 0; c--)
      if (vld[c] && (tags[c] == tag)) res = {1'b1, vals[c]};
    return res;
  endfunction

  logic [RS_ENTRIES-1:0]             s1_hit, s2_hit, kill;
  logic [RS_ENTRIES-1:0][DATA_W-1:0] s1_cdb, s2_cdb;

  always_comb begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      {s1_hit[i], s1_cdb[i]} = cdb_lookup(s1_tag[i], cdb_valid, cdb_tag, cdb_value);
      {s2_hit[i], s2_cdb[i]} = cdb_lookup(s2_tag[i], cdb_valid, cdb_tag, cdb_value);
      kill[i] = flush_all | (flush_en & is_younger(ent_rob[i], flush_rob_tag, rob_head_tag));
    end
  end

  logic [CNT_W-1:0]                  n_free;
  logic [ALLOC_W-1:0][IDX_W-1:0]     alloc_idx;

  always_comb begin
    n_free    = '0;
    alloc_idx = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (!ent_vld[i]) begin
        for (int k = 0; k < ALLOC_W; k++)
          if (n_free == CNT_W'(k)) alloc_idx[k] = IDX_W'(i);
        n_free = n_free + CNT_W'(1);
      end
    end
  end

  assign free_count  = n_free;
  assign alloc_ready = (n_free >= CNT_W'(ALLOC_W));

  logic [ALLOC_W-1:0]                 alloc_go, a1_hit, a2_hit;
  logic [ALLOC_W-1:0][DATA_W-1:0]     a1_cdb, a2_cdb;
  logic [ALLOC_W-1:0][RS_ENTRIES-1:0] older_alloc, younger_alloc;

  always_comb begin
    for (int k = 0; k < ALLOC_W; k++) begin
      {a1_hit[k], a1_cdb[k]} = cdb_lookup(alloc_src1_tag[k], cdb_valid, cdb_tag, cdb_value);
      {a2_hit[k], a2_cdb[k]} = cdb_lookup(alloc_src2_tag[k], cdb_valid, cdb_tag, cdb_value);
      alloc_go[k] = alloc_en[k] & alloc_ready & ~flush_all &
                    ~(flush_en & is_younger(alloc_rob_tag[k], flush_rob_tag, rob_head_tag));
    end
    // Same-cycle allocations: lower port is older than higher port.
    older_alloc   = '0;
    younger_alloc = '0;
    for (int k = 0; k < ALLOC_W; k++)
      for (int m = 0; m < ALLOC_W; m++)
        if (alloc_go[m]) begin
          if (m < k) older_alloc[k][alloc_idx[m]]   = 1'b1;
          if (m > k) younger_alloc[k][alloc_idx[m]] = 1'b1;
        end
  end

  logic [RS_ENTRIES-1:0] rdy1, rdy2, cand;

  always_comb begin
`ifdef RS_CDB_BYPASS_EN
    rdy1 = s1_rdy | s1_hit;
    rdy2 = s2_rdy | s2_hit;
`else
    rdy1 = s1_rdy;
    rdy2 = s2_rdy;
`endif
    cand = ent_vld & rdy1 & rdy2 & ~kill;
  end

  logic [ISSUE_W-1:0][IDX_W-1:0] sel;

  // Oldest-first select: an entry wins a port when no remaining candidate is older.
  always_comb begin
    logic [RS_ENTRIES-1:0] avail;
    logic                  oldest;
    avail       = cand;
    issue_valid = '0;
    sel         = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        oldest = avail[i];
        for (int j = 0; j < RS_ENTRIES; j++)
          if (avail[j] && older[j][i]) oldest = 1'b0;
        if (oldest && !issue_valid[p]) begin
          issue_valid[p] = 1'b1;
          sel[p]         = IDX_W'(i);
        end
      end
      if (issue_valid[p]) avail[sel[p]] = 1'b0;
    end
  end

  logic [RS_ENTRIES-1:0] iss_free;

  always_comb begin
    iss_free = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      issue_op[p]      = ent_op[sel[p]];
      issue_dst_tag[p] = ent_dst[sel[p]];
      issue_rob_tag[p] = ent_rob[sel[p]];
`ifdef RS_CDB_BYPASS_EN
      issue_src1_val[p] = s1_rdy[sel[p]] ? s1_val[sel[p]] : s1_cdb[sel[p]];
      issue_src2_val[p] = s2_rdy[sel[p]] ? s2_val[sel[p]] : s2_cdb[sel[p]];
`else
      issue_src1_val[p] = s1_val[sel[p]];
      issue_src2_val[p] = s2_val[sel[p]];
`endif
      if (issue_valid[p] && issue_ready[p]) iss_free[sel[p]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_vld <= '0;
      s1_rdy  <= '0;
      s2_rdy  <= '0;
      older   <= '0;
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (s1_hit[i]) s1_rdy[i] <= 1'b1;
        if (s2_hit[i]) s2_rdy[i] <= 1'b1;
        if (kill[i] || iss_free[i]) ent_vld[i] <= 1'b0;
      end
      for (int k = 0; k < ALLOC_W; k++)
        if (alloc_go[k]) begin
          ent_vld[alloc_idx[k]] <= 1'b1;
          s1_rdy[alloc_idx[k]]  <= alloc_src1_ready[k] | a1_hit[k];
          s2_rdy[alloc_idx[k]]  <= alloc_src2_ready[k] | a2_hit[k];
          for (int j = 0; j < RS_ENTRIES; j++) begin
            older[j][alloc_idx[k]] <= ent_vld[j] | older_alloc[k][j];
            older[alloc_idx[k]][j] <= younger_alloc[k][j];
          end
        end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (s1_hit[i] && !s1_rdy[i]) s1_val[i] <= s1_cdb[i];
      if (s2_hit[i] && !s2_rdy[i]) s2_val[i] <= s2_cdb[i];
    end
    for (int k = 0; k < ALLOC_W; k++)
      if (alloc_go[k]) begin
        ent_op[alloc_idx[k]]  <= alloc_op[k];
        ent_dst[alloc_idx[k]] <= alloc_dst_tag[k];
        ent_rob[alloc_idx[k]] <= alloc_rob_tag[k];
        s1_tag[alloc_idx[k]]  <= alloc_src1_tag[k];
        s2_tag[alloc_idx[k]]  <= alloc_src2_tag[k];
        s1_val[alloc_idx[k]]  <= alloc_src1_ready[k] ? alloc_src1_val[k] : a1_cdb[k];
        s2_val[alloc_idx[k]]  <= alloc_src2_ready[k] ? alloc_src2_val[k] : a2_cdb[k];
      end
  end

endmodule

// File: tb/tb_age_ordered_rs.sv
// Bench for age_ordered_rs: directed scenarios plus random traffic against a queue-based model.
module tb_age_ordered_rs;
  localparam int RS_ENTRIES = 16;
  localparam int ALLOC_W    = 2;
  localparam int ISSUE_W    = 2;
  localparam int CDB_W      = 2;
  localparam int PHYS_W     = 6;
  localparam int DATA_W     = 64;
  localparam int OP_W       = 8;
  localparam int ROB_W      = 6;
  localparam int CNT_W      = $clog2(RS_ENTRIES + 1);

  logic                           clk = 1'b0;
  logic                           reset;
  logic [ALLOC_W-1:0]             alloc_en;
  logic [ALLOC_W-1:0][OP_W-1:0]   alloc_op;
  logic [ALLOC_W-1:0][PHYS_W-1:0] alloc_dst_tag;
  logic [ALLOC_W-1:0][ROB_W-1:0]  alloc_rob_tag;
  logic [ALLOC_W-1:0][PHYS_W-1:0] alloc_src1_tag, alloc_src2_tag;
  logic [ALLOC_W-1:0][DATA_W-1:0] alloc_src1_val, alloc_src2_val;
  logic [ALLOC_W-1:0]             alloc_src1_ready, alloc_src2_ready;
  logic                           alloc_ready;
  logic [CNT_W-1:0]               free_count;
  logic [CDB_W-1:0]               cdb_valid;
  logic [CDB_W-1:0][PHYS_W-1:0]   cdb_tag;
  logic [CDB_W-1:0][DATA_W-1:0]   cdb_value;
  logic [ISSUE_W-1:0]             issue_valid, issue_ready;
  logic [ISSUE_W-1:0][OP_W-1:0]   issue_op;
  logic [ISSUE_W-1:0][PHYS_W-1:0] issue_dst_tag;
  logic [ISSUE_W-1:0][ROB_W-1:0]  issue_rob_tag;
  logic [ISSUE_W-1:0][DATA_W-1:0] issue_src1_val, issue_src2_val;
  logic                           flush_all, flush_en;
  logic [ROB_W-1:0]               flush_rob_tag, rob_head_tag;

  age_ordered_rs #(
    .RS_ENTRIES(RS_ENTRIES), .ALLOC_W(ALLOC_W), .ISSUE_W(ISSUE_W), .CDB_W(CDB_W),
    .PHYS_W(PHYS_W), .DATA_W(DATA_W), .OP_W(OP_W), .ROB_W(ROB_W)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_en(alloc_en), .alloc_op(alloc_op), .alloc_dst_tag(alloc_dst_tag),
    .alloc_rob_tag(alloc_rob_tag), .alloc_src1_tag(alloc_src1_tag),
    .alloc_src2_tag(alloc_src2_tag), .alloc_src1_val(alloc_src1_val),
    .alloc_src2_val(alloc_src2_val), .alloc_src1_ready(alloc_src1_ready),
    .alloc_src2_ready(alloc_src2_ready), .alloc_ready(alloc_ready),
    .free_count(free_count), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_dst_tag(issue_dst_tag), .issue_rob_tag(issue_rob_tag),
    .issue_src1_val(issue_src1_val), .issue_src2_val(issue_src2_val),
    .flush_all(flush_all), .flush_en(flush_en), .flush_rob_tag(flush_rob_tag),
    .rob_head_tag(rob_head_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [PHYS_W-1:0] dst;
    logic [ROB_W-1:0]  rob;
    logic              r1, r2;
    logic [PHYS_W-1:0] t1, t2;
    logic [DATA_W-1:0] v1, v2;
    int                seq;
  } ment_t;

  ment_t mq[$];
  int    seq_ctr = 0;
  int    errors  = 0;
  int    checks  = 0;

  logic [ISSUE_W-1:0]             exp_iv;
  int                             exp_pos [ISSUE_W];
  logic [ISSUE_W-1:0][DATA_W-1:0] exp_v1, exp_v2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit cdb_hit(input logic [PHYS_W-1:0] t, output logic [DATA_W-1:0] v);
    v = '0;
    for (int c = 0; c < CDB_W; c++)
      if (cdb_valid[c] && cdb_tag[c] == t) begin
        v = cdb_value[c];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic int rob_age(input logic [ROB_W-1:0] t);
    return (int'(t) - int'(rob_head_tag) + (1 << ROB_W)) % (1 << ROB_W);
  endfunction

  function automatic bit squashed(input logic [ROB_W-1:0] t);
    return flush_all || (flush_en && rob_age(t) > rob_age(flush_rob_tag));
  endfunction

  task automatic model_eval();
    bit                cand[$];
    bit                r1, r2;
    int                best;
    logic [DATA_W-1:0] v;
    exp_iv = '0;
    for (int i = 0; i < mq.size(); i++) begin
      r1 = mq[i].r1;
      r2 = mq[i].r2;
`ifdef RS_CDB_BYPASS_EN
      if (!r1) r1 = cdb_hit(mq[i].t1, v);
      if (!r2) r2 = cdb_hit(mq[i].t2, v);
`endif
      cand.push_back(r1 && r2 && !squashed(mq[i].rob));
    end
    for (int p = 0; p < ISSUE_W; p++) begin
      best = -1;
      for (int i = 0; i < mq.size(); i++)
        if (cand[i] && (best < 0 || mq[i].seq < mq[best].seq)) best = i;
      exp_pos[p] = best;
      if (best >= 0) begin
        exp_iv[p] = 1'b1;
        cand[best] = 1'b0;
        if (mq[best].r1) exp_v1[p] = mq[best].v1;
        else begin void'(cdb_hit(mq[best].t1, v)); exp_v1[p] = v; end
        if (mq[best].r2) exp_v2[p] = mq[best].v2;
        else begin void'(cdb_hit(mq[best].t2, v)); exp_v2[p] = v; end
      end
    end
  endtask

  task automatic compare();
    check("free_count", 64'(free_count), 64'(RS_ENTRIES - mq.size()));
    check("alloc_ready", 64'(alloc_ready), 64'((RS_ENTRIES - mq.size()) >= ALLOC_W));
    check("issue_valid", 64'(issue_valid), 64'(exp_iv));
    for (int p = 0; p < ISSUE_W; p++)
      if (exp_iv[p] && issue_valid[p]) begin
        check("issue_op", 64'(issue_op[p]), 64'(mq[exp_pos[p]].op));
        check("issue_dst", 64'(issue_dst_tag[p]), 64'(mq[exp_pos[p]].dst));
        check("issue_rob", 64'(issue_rob_tag[p]), 64'(mq[exp_pos[p]].rob));
        check("issue_src1", issue_src1_val[p], exp_v1[p]);
        check("issue_src2", issue_src2_val[p], exp_v2[p]);
      end
  endtask

  task automatic model_commit();
    ment_t             nq[$];
    ment_t             e;
    logic [DATA_W-1:0] v;
    bit                keep, acc;
    acc = (RS_ENTRIES - mq.size()) >= ALLOC_W;
    for (int i = 0; i < mq.size(); i++) begin
      e    = mq[i];
      keep = !squashed(e.rob);
      for (int p = 0; p < ISSUE_W; p++)
        if (exp_iv[p] && issue_ready[p] && exp_pos[p] == i) keep = 1'b0;
      if (!e.r1 && cdb_hit(e.t1, v)) begin e.r1 = 1'b1; e.v1 = v; end
      if (!e.r2 && cdb_hit(e.t2, v)) begin e.r2 = 1'b1; e.v2 = v; end
      if (keep) nq.push_back(e);
    end
    if (acc)
      for (int k = 0; k < ALLOC_W; k++)
        if (alloc_en[k] && !squashed(alloc_rob_tag[k])) begin
          e.op  = alloc_op[k];
          e.dst = alloc_dst_tag[k];
          e.rob = alloc_rob_tag[k];
          e.t1  = alloc_src1_tag[k];
          e.t2  = alloc_src2_tag[k];
          e.r1  = alloc_src1_ready[k];
          e.r2  = alloc_src2_ready[k];
          e.v1  = alloc_src1_val[k];
          e.v2  = alloc_src2_val[k];
          if (!e.r1 && cdb_hit(e.t1, v)) begin e.r1 = 1'b1; e.v1 = v; end
          if (!e.r2 && cdb_hit(e.t2, v)) begin e.r2 = 1'b1; e.v2 = v; end
          e.seq = seq_ctr++;
          nq.push_back(e);
        end
    mq = nq;
  endtask

  task automatic sample();
    #1;
    model_eval();
    compare();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic idle();
    alloc_en = '0; alloc_op = '0; alloc_dst_tag = '0; alloc_rob_tag = '0;
    alloc_src1_tag = '0; alloc_src2_tag = '0; alloc_src1_val = '0; alloc_src2_val = '0;
    alloc_src1_ready = '0; alloc_src2_ready = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    issue_ready = '0; flush_all = 1'b0; flush_en = 1'b0;
    flush_rob_tag = '0; rob_head_tag = '0;
  endtask

  task automatic set_alloc(input int k, input logic [OP_W-1:0] op, input logic [PHYS_W-1:0] dst,
                           input logic [ROB_W-1:0] rob,
                           input logic [PHYS_W-1:0] t1, input logic r1, input logic [DATA_W-1:0] v1,
                           input logic [PHYS_W-1:0] t2, input logic r2, input logic [DATA_W-1:0] v2);
    alloc_en[k] = 1'b1;        alloc_op[k] = op;
    alloc_dst_tag[k] = dst;    alloc_rob_tag[k] = rob;
    alloc_src1_tag[k] = t1;    alloc_src1_ready[k] = r1;  alloc_src1_val[k] = v1;
    alloc_src2_tag[k] = t2;    alloc_src2_ready[k] = r2;  alloc_src2_val[k] = v2;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b1;
    #2;
    check("rst_free_count", 64'(free_count), 64'(RS_ENTRIES));
    check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ADD p10=5+3 and SUB p11=p10-7, then CDB {p10,8}
    issue_ready = 2'b11;
    set_alloc(0, 8'h01, 6'd10, 6'd0, 6'd0, 1'b1, 64'd5, 6'd0, 1'b1, 64'd3);
    set_alloc(1, 8'h02, 6'd11, 6'd1, 6'd10, 1'b0, 64'd0, 6'd0, 1'b1, 64'd7);
    step();
    alloc_en = '0;
    sample();
    check("add_valid", 64'(issue_valid[0]), 64'd1);
    check("add_src1", issue_src1_val[0], 64'd5);
    check("add_src2", issue_src2_val[0], 64'd3);
    check("add_dst", 64'(issue_dst_tag[0]), 64'd10);
    advance();
    cdb_valid = 2'b01; cdb_tag[0] = 6'd10; cdb_value[0] = 64'd8;
    sample();
`ifdef RS_CDB_BYPASS_EN
    check("sub_bypass_valid", 64'(issue_valid[0]), 64'd1);
    check("sub_bypass_src1", issue_src1_val[0], 64'd8);
    advance();
    cdb_valid = '0;
`else
    check("sub_wait_valid", 64'(issue_valid), 64'd0);
    advance();
    cdb_valid = '0;
    sample();
    check("sub_valid", 64'(issue_valid[0]), 64'd1);
    check("sub_src1", issue_src1_val[0], 64'd8);
    check("sub_src2", issue_src2_val[0], 64'd7);
    advance();
`endif

    // Fill RS_ENTRIES-1 entries with waiting sources
    issue_ready = '0;
    for (int c = 0; c < (RS_ENTRIES / 2); c++) begin
      alloc_en = '0;
      set_alloc(0, 8'h10, 6'(2 * c), 6'(2 * c), 6'd40, 1'b0, 64'd0, 6'd40, 1'b0, 64'd0);
      if (c < (RS_ENTRIES / 2) - 1)
        set_alloc(1, 8'h11, 6'(2 * c + 1), 6'(2 * c + 1), 6'd40, 1'b0, 64'd0, 6'd40, 1'b0, 64'd0);
      step();
    end
    alloc_en = '0;
    sample();
    check("full_free_count", 64'(free_count), 64'd1);
    check("full_alloc_ready", 64'(alloc_ready), 64'd0);
    advance();
    set_alloc(0, 8'h12, 6'd1, 6'd30, 6'd1, 1'b1, 64'd1, 6'd1, 1'b1, 64'd1);
    set_alloc(1, 8'h13, 6'd2, 6'd31, 6'd1, 1'b1, 64'd1, 6'd1, 1'b1, 64'd1);
    step();
    alloc_en = '0;
    sample();
    check("full_hold_free_count", 64'(free_count), 64'd1);
    advance();
    flush_all = 1'b1;
    step();
    flush_all = 1'b0;
    sample();
    check("flush_all_free_count", 64'(free_count), 64'(RS_ENTRIES));
    advance();

    // Age order across two allocation cycles
    issue_ready = 2'b11;
    set_alloc(0, 8'h20, 6'd4, 6'd4, 6'd0, 1'b1, 64'h44, 6'd0, 1'b1, 64'h4);
    set_alloc(1, 8'h21, 6'd5, 6'd5, 6'd0, 1'b1, 64'h55, 6'd0, 1'b1, 64'h5);
    step();
    set_alloc(0, 8'h22, 6'd6, 6'd6, 6'd0, 1'b1, 64'h66, 6'd0, 1'b1, 64'h6);
    set_alloc(1, 8'h23, 6'd7, 6'd7, 6'd0, 1'b1, 64'h77, 6'd0, 1'b1, 64'h7);
    sample();
    check("age_c1_p0_rob", 64'(issue_rob_tag[0]), 64'd4);
    check("age_c1_p1_rob", 64'(issue_rob_tag[1]), 64'd5);
    advance();
    alloc_en = '0;
    sample();
    check("age_c2_p0_rob", 64'(issue_rob_tag[0]), 64'd6);
    check("age_c2_p1_rob", 64'(issue_rob_tag[1]), 64'd7);
    advance();

    // Backpressure: hold, then accept on port 0 only
    issue_ready = '0;
    set_alloc(0, 8'h30, 6'd8, 6'd8, 6'd0, 1'b1, 64'h8, 6'd0, 1'b1, 64'h8);
    set_alloc(1, 8'h31, 6'd9, 6'd9, 6'd0, 1'b1, 64'h9, 6'd0, 1'b1, 64'h9);
    step();
    alloc_en = '0;
    for (int c = 0; c < 3; c++) begin
      sample();
      check("bp_hold_valid", 64'(issue_valid), 64'd3);
      check("bp_hold_free_count", 64'(free_count), 64'(RS_ENTRIES - 2));
      advance();
    end
    issue_ready = 2'b01;
    step();
    issue_ready = '0;
    sample();
    check("bp_one_free_count", 64'(free_count), 64'(RS_ENTRIES - 1));
    advance();
    issue_ready = 2'b11;
    step();
    issue_ready = '0;

    // Selective flush across ROB tag wrap
    rob_head_tag = 6'd60;
    set_alloc(0, 8'h40, 6'd1, 6'd62, 6'd40, 1'b0, 64'd0, 6'd40, 1'b0, 64'd0);
    set_alloc(1, 8'h41, 6'd2, 6'd63, 6'd40, 1'b0, 64'd0, 6'd40, 1'b0, 64'd0);
    step();
    set_alloc(0, 8'h42, 6'd3, 6'd0, 6'd40, 1'b0, 64'd0, 6'd40, 1'b0, 64'd0);
    set_alloc(1, 8'h43, 6'd4, 6'd1, 6'd40, 1'b0, 64'd0, 6'd40, 1'b0, 64'd0);
    step();
    alloc_en = '0;
    flush_en = 1'b1; flush_rob_tag = 6'd63;
    step();
    flush_en = 1'b0;
    sample();
    check("sel_flush_free_count", 64'(free_count), 64'(RS_ENTRIES - 2));
    advance();
    flush_all = 1'b1;
    step();
    flush_all = 1'b0;
    rob_head_tag = '0;

    // Same-cycle CDB capture at allocation, then the same with flush_all
    issue_ready = 2'b01;
    set_alloc(0, 8'h50, 6'd21, 6'd2, 6'd20, 1'b0, 64'd0, 6'd0, 1'b1, 64'h11);
    cdb_valid = 2'b10; cdb_tag[1] = 6'd20; cdb_value[1] = 64'hABCD;
    step();
    alloc_en = '0; cdb_valid = '0;
    sample();
    check("capture_valid", 64'(issue_valid[0]), 64'd1);
    check("capture_src1", issue_src1_val[0], 64'hABCD);
    advance();
    set_alloc(0, 8'h51, 6'd22, 6'd3, 6'd20, 1'b0, 64'd0, 6'd0, 1'b1, 64'h11);
    cdb_valid = 2'b01; cdb_tag[0] = 6'd20; cdb_value[0] = 64'h1234;
    flush_all = 1'b1;
    step();
    alloc_en = '0; cdb_valid = '0; flush_all = 1'b0;
    sample();
    check("capture_flush_free_count", 64'(free_count), 64'(RS_ENTRIES));
    advance();

    // Random traffic
    for (int cyc = 0; cyc < 1500; cyc++) begin
      alloc_en = ALLOC_W'($urandom);
      for (int k = 0; k < ALLOC_W; k++) begin
        alloc_op[k]         = OP_W'($urandom);
        alloc_dst_tag[k]    = PHYS_W'($urandom);
        alloc_rob_tag[k]    = ROB_W'($urandom);
        alloc_src1_tag[k]   = PHYS_W'($urandom_range(0, 7));
        alloc_src2_tag[k]   = PHYS_W'($urandom_range(0, 7));
        alloc_src1_ready[k] = ($urandom_range(0, 2) == 0);
        alloc_src2_ready[k] = ($urandom_range(0, 2) == 0);
        alloc_src1_val[k]   = {$urandom, $urandom};
        alloc_src2_val[k]   = {$urandom, $urandom};
      end
      cdb_valid = CDB_W'($urandom);
      for (int c = 0; c < CDB_W; c++) begin
        cdb_tag[c]   = PHYS_W'($urandom_range(0, 7));
        cdb_value[c] = {$urandom, $urandom};
      end
      issue_ready   = ISSUE_W'($urandom);
      flush_all     = ($urandom_range(0, 99) == 0);
      flush_en      = ($urandom_range(0, 19) == 0);
      rob_head_tag  = ROB_W'($urandom);
      flush_rob_tag = ROB_W'($urandom);
      step();
    end

    // Asynchronous reset mid-operation
    idle();
    for (int c = 0; c < 4; c++) begin
      set_alloc(0, 8'h60, 6'd1, 6'(c), 6'd40, 1'b0, 64'd0, 6'd40, 1'b0, 64'd0);
      set_alloc(1, 8'h61, 6'd2, 6'(c), 6'd0, 1'b1, 64'd1, 6'd0, 1'b1, 64'd2);
      step();
    end
    idle();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_free_count", 64'(free_count), 64'(RS_ENTRIES));
    check("async_rst_issue_valid", 64'(issue_valid), 64'd0);
    check("async_rst_alloc_ready", 64'(alloc_ready), 64'd1);
    mq.delete();
    @(negedge clk);
    reset = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/age_ordered_rs.md
Name: age_ordered_rs

Overview:
- Parametrised successor to the core's single-queue reservation station.
- Holds renamed µops until both operands are available, then issues the oldest ready entries to ISSUE_W execution ports.
- Additions over the previous generation:
  - independent ALLOC_W / ISSUE_W / CDB_W widths;
  - exact oldest-first select via an age matrix;
  - per-port issue backpressure;
  - allocation flow control;
  - full and ROB-age selective flush for branch recovery.
- Sits between rename/dispatch and the integer execution units; snoops the CDB.

Parameters:
- RS_ENTRIES, 16, number of entries (power of 2 not required, ≥ ALLOC_W).
- ALLOC_W, 2, dispatch ports per cycle.
- ISSUE_W, 2, issue ports per cycle.
- CDB_W, 2, CDB broadcast ports.
- PHYS_W, 6, physical tag width.
- DATA_W, 64, operand width.
- OP_W, 8, opcode width.
- ROB_W, 6, ROB tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- alloc_en  in  ALLOC_W  per-port dispatch request.
- alloc_op / alloc_dst_tag / alloc_rob_tag  in  ALLOC_W×(OP_W / PHYS_W / ROB_W)  µop fields.
- alloc_src1_tag, alloc_src2_tag  in  ALLOC_W×PHYS_W  source tags.
- alloc_src1_val, alloc_src2_val  in  ALLOC_W×DATA_W  source values, valid when ready.
- alloc_src1_ready, alloc_src2_ready  in  ALLOC_W  source-ready flags.
- alloc_ready  out  1  high when free entries ≥ ALLOC_W.
- free_count  out  $clog2(RS_ENTRIES+1)  number of invalid entries.
- cdb_valid  in  CDB_W  broadcast valid.
- cdb_tag  in  CDB_W×PHYS_W  broadcast tag.
- cdb_value  in  CDB_W×DATA_W  broadcast value.
- issue_valid  out  ISSUE_W  entry presented on port.
- issue_ready  in  ISSUE_W  execution unit accepts.
- issue_op / issue_dst_tag / issue_rob_tag  out  per-port µop fields.
- issue_src1_val, issue_src2_val  out  ISSUE_W×DATA_W  operand values.
- flush_all  in  1  squash every entry.
- flush_en  in  1  selective squash request.
- flush_rob_tag  in  ROB_W  tag of the mispredicted branch.
- rob_head_tag  in  ROB_W  current ROB head, used as the age reference.

Behaviour:
- Reset:
  - all entries invalid, age matrix cleared;
  - issue_valid=0, alloc_ready=1, free_count=RS_ENTRIES.
- Allocation:
  - Accepted only when alloc_ready=1. If alloc_ready=0, all alloc_en are ignored (no partial accept).
  - Port k writes the k-th lowest-indexed free entry on the clock edge.
  - Same-cycle allocations: lower port is older; every new entry is younger than all resident entries.
  - alloc_ready and free_count reflect registered state only; same-cycle issue frees are not counted.
- Wakeup:
  - Each cycle, any waiting source whose tag equals a valid cdb_tag sets ready and latches cdb_value.
  - An allocating source with ready=0 whose tag matches the CDB in the same cycle is captured ready (no lost wakeup).
  - If multiple CDB ports match, the lowest CDB index wins.
- Select:
  - Candidate = valid & src1 ready & src2 ready.
  - Port 0 takes the oldest candidate; port p takes the oldest candidate not taken by ports < p.
  - Entries allocated this cycle are not candidates until the next cycle.
  - Issue outputs are combinational from entry state.
- Issue handshake:
  - An entry is freed at the edge where issue_valid[p] & issue_ready[p].
  - If issue_ready[p]=0, the entry stays valid and selection is recomputed next cycle; stability of the presented entry is not guaranteed.
- Flush:
  - Age of a tag = (tag − rob_head_tag) mod 2^ROB_W.
  - flush_en invalidates every entry, and every same-cycle alloc, whose age > age(flush_rob_tag).
  - flush_all invalidates everything and drops same-cycle allocs.
  - Flush takes priority over issue acceptance and wakeup for squashed entries; surviving entries still wake and issue normally.
  - flush_all and flush_en together: flush_all wins.
- Full:
  - free_count < ALLOC_W ⇒ alloc_ready=0.
  - free_count=0 with no candidates ⇒ issue_valid=0, state holds.
- Reset asserted mid-operation clears state immediately, asynchronously.

Optional Feature:
- RS_CDB_BYPASS_EN.
- Defined:
  - A resident entry woken by the CDB is a select candidate in the same cycle.
  - Its issue_srcN_val is driven directly from cdb_value (zero-latency back-to-back dependent issue).
- Undefined:
  - Wakeup is registered; a woken entry is first a candidate the following cycle.
  - Shorter critical path.

Test Plan:
- Reset, then alloc ADD p10=5+3 (ready) and SUB p11=p10−7 (waiting), issue_ready=11 → next cycle ADD issues with vals 5,3 to p10. With a CDB {p10, 8} the SUB issues with src1=8: the same cycle as the broadcast with RS_CDB_BYPASS_EN, one cycle later without it.
- Fill RS_ENTRIES−1 entries with waiting sources → free_count=1 and alloc_ready=0; an alloc_en=11 pulse leaves free_count=1.
- Four ready entries allocated over two cycles in ROB order 4,5,6,7 with issue_ready=11 → cycle 1 issues ROB 4 and 5, cycle 2 issues ROB 6 and 7.
- issue_ready=00 for 3 cycles with 2 ready entries → issue_valid=11 held and entries remain. Setting issue_ready=01 then frees exactly one entry.
- rob_head_tag=60, entries with ROB 62, 63, 0, 1; flush_en with flush_rob_tag=63 → only ROB 62 and 63 remain, free_count=RS_ENTRIES−2.
- CDB broadcast of p20 in the same cycle as alloc of an entry with src1_tag=20, ready=0 → entry captured ready with the CDB value; flush_all that cycle instead → free_count=RS_ENTRIES.
